cpu: RTL and testbench
======================

// Module: cpu
// PURPOSE
// - 5-stage in-order pipelined 32-bit MIPS-subset CPU: IF, ID, EX, MEM, WB.
// - Top of the processor. Contains PC, instruction memory, register file, control,
//   hazard detection, forwarding and data memory.
// - Program and data are preloaded hierarchically by the bench. The core runs on
//   start_i and has no external bus.
// PARAMETERS
// IMEM_WORDS  256  instruction memory depth (32-bit words; memory[])
// DMEM_BYTES  32   data memory depth (bytes; memory[], little-endian)
// PORTS
// clk_i    in   1   clock; all state updates on rising edge
// rst_i    in   1   synchronous active-high reset
// start_i  in   1   run enable; 0 = PC holds and no new fetch (bubbles enter ID)
// pc_o     out  32  current PC (IF stage)
// stall_o  out  1   load-use stall asserted this cycle
// flush_o  out  1   IF/ID flush (taken beq or j) asserted this cycle
// BEHAVIOUR
// - Reset (rst_i=1 at edge): PC=0, all pipeline control bits cleared (NOPs), pc_o=0.
//   stall_o=0, flush_o=0. Register file and memories are not cleared. Reset wins over
//   every other event, including mid-operation.
// - ISA, MIPS encodings:
//   - R-type op=0: add 0x20, sub 0x22, and 0x24, or 0x25, mul 0x18
//     (rd = low 32 bits of rs*rs... i.e. rs*rt).
//   - I-type: addi 0x08 (sign-extended imm), lw 0x23, sw 0x2B, beq 0x04.
//   - J-type: j 0x02.
//   - Any other word executes as NOP; 32'b0 is a NOP.
// - IF:
//   - inst = imem[pc[9:2]].
//   - Next PC = pc+4, unless stall (hold) or ID redirect.
// - ID:
//   - Register read with write-first bypass: a WB write to the same reg in the same
//     cycle is seen.
//   - beq is resolved in ID by comparing the register values. Target = PC+4 + (sext(imm)<<2).
//   - j target = {PC+4[31:28], addr26, 2'b00}.
//   - Taken beq or j: PC <= target and IF/ID is flushed to NOP (1-cycle penalty);
//     flush_o=1 that cycle.
//   - Branch operands are not forwarded from EX/MEM. Software keeps a 2-instruction gap
//     before a dependent beq.
// - Load-use hazard:
//   - Condition: ID_EX.MemRd && ID_EX.rt != 0 && (ID_EX.rt == IF_ID.rs || ID_EX.rt == IF_ID.rt).
//   - Effect: PC and IF/ID hold, ID/EX gets a bubble; stall_o=1 for exactly 1 cycle.
//   - A stall suppresses the branch/jump decision that cycle.
// - EX forwarding, per ALU operand:
//   - EX/MEM has priority over MEM/WB.
//   - Only when that stage has RegWrite=1 and a destination register != 0.
//   - EX/MEM forwards its ALU result; MEM/WB forwards the WB mux output.
// - ALU is 32-bit wrap-around; no overflow traps.
// - Destination register: rd for R-type, rt for addi/lw.
// - MEM: byte address = ALU result.
//   - lw reads bytes a..a+3 little-endian; sw writes them.
//   - Address is taken mod DMEM_BYTES; unaligned addresses are unsupported.
// - WB: register r0 is never written and always reads 0.
// - start_i=0: PC holds; instructions already in the pipeline drain normally.
// TESTING
// - dmem[0]=5; lw r8,0(r0) -> r8=5 after 5 cycles; dmem bytes unchanged.
// - addi r1,r0,3; add r2,r1,r1; sub r3,r2,r1 -> r2=6, r3=3; forwarding used, stall count 0.
// - lw r8,0(r0); add r9,r8,r8 (dmem[0]=5) -> exactly 1 stall_o pulse; r9=10.
// - addi r1,r0,1; nop; nop; beq r1,r1,+2 -> 1 flush_o pulse; skipped instrs do not write;
//   PC lands at beq+12.
// - j to 0x20 -> 1 flush_o pulse, next fetch pc_o=0x20.
// - sw r2,4(r0) with r2=6 -> dmem word 0x04=6.
// - Assert rst_i mid-loop -> next cycle pc_o=0, no stale writeback.

Source files
------------

// File: rtl/cpu.sv
// cpu: 5-stage in-order MIPS-subset core (IF/ID/EX/MEM/WB) with EX forwarding,
// load-use stall and ID-stage beq/j resolution; memories are preloaded externally.
module cpu #(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_BYTES = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic [31:0] pc_o,
  output logic        stall_o,
  output logic        flush_o
);
  localparam int AW = $clog2(DMEM_BYTES);
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } if_id_t;
  typedef struct packed {
    logic        rw;
    logic        mr;
    logic        mw;
    logic        src;
    logic [2:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
  } id_ex_t;
  typedef struct packed {
    logic        rw;
    logic        mr;
    logic        mw;
    logic [4:0]  dst;
    logic [31:0] alu;
    logic [31:0] sd;
  } ex_mem_t;
  typedef struct packed {
    logic        rw;
    logic        mr;
    logic [4:0]  dst;
    logic [31:0] alu;
    logic [31:0] ld;
  } mem_wb_t;
  logic [31:0] imem [IMEM_WORDS];
  logic [7:0]  dmem [DMEM_BYTES];
  logic [31:0] rf   [32];
  logic [31:0] pc_q, pc_d, pc4, inst;
  if_id_t      if_id_q, if_id_d;
  id_ex_t      id_ex_q, id_ex_d;
  ex_mem_t     ex_mem_q, ex_mem_d;
  mem_wb_t     mem_wb_q, mem_wb_d;
  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd, wb_rd;
  logic [31:0] imm, rs_v, rt_v, wb_d, br_t, j_t, fa, fb, alu_b, alu_y;
  logic        is_r, is_addi, is_lw, is_sw, is_beq, is_j, ld_use, take, wb_we;
  logic [AW-1:0] ma;
  logic        unused_shamt;
  assign pc4  = pc_q + 32'd4;
  assign inst = imem[pc_q[9:2]];
  assign op   = if_id_q.instr[31:26];
  assign fn   = if_id_q.instr[5:0];
  assign rs   = if_id_q.instr[25:21];
  assign rt   = if_id_q.instr[20:16];
  assign rd   = if_id_q.instr[15:11];
  assign imm  = {{16{if_id_q.instr[15]}}, if_id_q.instr[15:0]};
  assign unused_shamt = ^if_id_q.instr[10:6];
  assign is_r    = op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h18);
  assign is_addi = op == 6'h08;
  assign is_lw   = op == 6'h23;
  assign is_sw   = op == 6'h2B;
  assign is_beq  = op == 6'h04;
  assign is_j    = op == 6'h02;
  assign wb_we = mem_wb_q.rw && mem_wb_q.dst != 5'd0;
  assign wb_rd = mem_wb_q.dst;
  assign wb_d  = mem_wb_q.mr ? mem_wb_q.ld : mem_wb_q.alu;
  assign rs_v  = rs == 5'd0 ? 32'd0 : (wb_we && wb_rd == rs) ? wb_d : rf[rs];
  assign rt_v  = rt == 5'd0 ? 32'd0 : (wb_we && wb_rd == rt) ? wb_d : rf[rt];
  assign ld_use = id_ex_q.mr && id_ex_q.rt != 5'd0 && (id_ex_q.rt == rs || id_ex_q.rt == rt);
  assign take   = !ld_use && ((is_beq && rs_v == rt_v) || is_j);
  assign br_t   = if_id_q.pc4 + (imm << 2);
  assign j_t    = {if_id_q.pc4[31:28], if_id_q.instr[25:0], 2'b00};
  assign ma     = ex_mem_q.alu[AW-1:0];
  assign pc_o    = pc_q;
  assign stall_o = ld_use;
  assign flush_o = take;
  always_comb begin
    pc_d    = ld_use ? pc_q : take ? (is_j ? j_t : br_t) : start_i ? pc4 : pc_q;
    if_id_d = ld_use ? if_id_q : (take || !start_i) ? '0 : if_id_t'{inst, pc4};
    id_ex_d = '0;
    if (!ld_use) begin
      id_ex_d.rw  = is_r | is_addi | is_lw;
      id_ex_d.mr  = is_lw;
      id_ex_d.mw  = is_sw;
      id_ex_d.src = is_addi | is_lw | is_sw;
      id_ex_d.op  = !is_r ? 3'd0 : fn == 6'h22 ? 3'd1 : fn == 6'h24 ? 3'd2 : fn == 6'h25 ? 3'd3 : fn == 6'h18 ? 3'd4 : 3'd0;
      id_ex_d.rs  = rs;
      id_ex_d.rt  = rt;
      id_ex_d.dst = is_r ? rd : rt;
      id_ex_d.a   = rs_v;
      id_ex_d.b   = rt_v;
      id_ex_d.imm = imm;
    end
  end
  // EX/MEM beats MEM/WB; a stage only forwards when it writes a non-zero register
  always_comb begin
    fa = (ex_mem_q.rw && ex_mem_q.dst != 5'd0 && ex_mem_q.dst == id_ex_q.rs) ? ex_mem_q.alu :
         (wb_we && wb_rd == id_ex_q.rs) ? wb_d : id_ex_q.a;
    fb = (ex_mem_q.rw && ex_mem_q.dst != 5'd0 && ex_mem_q.dst == id_ex_q.rt) ? ex_mem_q.alu :
         (wb_we && wb_rd == id_ex_q.rt) ? wb_d : id_ex_q.b;
    alu_b = id_ex_q.src ? id_ex_q.imm : fb;
    alu_y = id_ex_q.op == 3'd1 ? fa - alu_b :
            id_ex_q.op == 3'd2 ? fa & alu_b :
            id_ex_q.op == 3'd3 ? fa | alu_b :
            id_ex_q.op == 3'd4 ? fa * alu_b : fa + alu_b;
    ex_mem_d = ex_mem_t'{id_ex_q.rw, id_ex_q.mr, id_ex_q.mw, id_ex_q.dst, alu_y, fb};
    mem_wb_d = mem_wb_t'{ex_mem_q.rw, ex_mem_q.mr, ex_mem_q.dst, ex_mem_q.alu,
                         {dmem[ma + AW'(3)], dmem[ma + AW'(2)], dmem[ma + AW'(1)], dmem[ma]}};
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q     <= '0;
      if_id_q  <= '0;
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      pc_q     <= pc_d;
      if_id_q  <= if_id_d;
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
      if (ex_mem_q.mw) begin
        dmem[ma]          <= ex_mem_q.sd[7:0];
        dmem[ma + AW'(1)] <= ex_mem_q.sd[15:8];
        dmem[ma + AW'(2)] <= ex_mem_q.sd[23:16];
        dmem[ma + AW'(3)] <= ex_mem_q.sd[31:24];
      end
      if (wb_we) rf[wb_rd] <= wb_d;
    end
  end
endmodule

// File: tb/tb_cpu.sv
// tb_cpu: random and directed programs against an ISA-level interpreter; a
// writeback scoreboard plus final register/memory and hazard-pulse checks.
module tb_cpu;
  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] pc_o;
  logic        stall_o, flush_o;
  cpu dut (.clk_i(clk), .rst_i(rst_i), .start_i(start_i), .pc_o(pc_o), .stall_o(stall_o), .flush_o(flush_o));
  always #5 clk = ~clk;
  typedef struct {
    logic [4:0]  r;
    logic [31:0] v;
  } wr_t;
  wr_t         exp_q[$];
  wr_t         e_mon;
  logic [31:0] prog [256];
  logic [7:0]  mem0 [32];
  logic [31:0] m_rf [32];
  logic [7:0]  m_mem [32];
  int          n_chk = 0, n_pass = 0, n_stall = 0, n_flush = 0;
  logic [31:0] pc_after_flush = '1;
  bit          cnt_on = 0, sb_on = 0, flush_pend = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  function automatic logic [31:0] r_op(input logic [5:0] f, input int d, input int s, input int t);
    return {6'd0, 5'(s), 5'(t), 5'(d), 5'd0, f};
  endfunction
  function automatic logic [31:0] i_op(input logic [5:0] o, input int t, input int s, input logic [15:0] im);
    return {o, 5'(s), 5'(t), im};
  endfunction
  // Architectural interpreter: sequential semantics, no pipeline notion at all
  function automatic void model(input int len);
    int pc, nxt, steps, dst, ad;
    logic [31:0] w, a, b, se, res, ea;
    pc = 0;
    steps = 0;
    for (int i = 0; i < 32; i++) begin
      m_rf[i] = 0;
      m_mem[i] = mem0[i];
    end
    while (pc < len && steps < 1000) begin
      w = prog[pc];
      a = m_rf[w[25:21]];
      b = m_rf[w[20:16]];
      se = {{16{w[15]}}, w[15:0]};
      ea = a + se;
      ad = int'(ea[4:0]);
      nxt = pc + 1;
      dst = 0;
      res = 0;
      case (w[31:26])
        6'h00: begin
          dst = int'(w[15:11]);
          case (w[5:0])
            6'h20: res = a + b;
            6'h22: res = a - b;
            6'h24: res = a & b;
            6'h25: res = a | b;
            6'h18: res = a * b;
            default: dst = 0;
          endcase
        end
        6'h08: begin dst = int'(w[20:16]); res = ea; end
        6'h23: begin
          dst = int'(w[20:16]);
          res = {m_mem[(ad + 3) % 32], m_mem[(ad + 2) % 32], m_mem[(ad + 1) % 32], m_mem[ad]};
        end
        6'h2B: for (int k = 0; k < 4; k++) m_mem[(ad + k) % 32] = 8'(b >> (8 * k));
        6'h04: if (a == b) nxt = pc + 1 + $signed(se);
        6'h02: nxt = int'(w[25:0]);
        default: dst = 0;
      endcase
      if (dst != 0) begin
        m_rf[dst] = res;
        exp_q.push_back('{r: 5'(dst), v: res});
      end
      pc = nxt;
      steps++;
    end
  endfunction
  always @(negedge clk) begin
    if (sb_on && !rst_i && dut.wb_we) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL wb_extra: got write r%0d=0x%0h expected no write", dut.wb_rd, dut.wb_d);
      end else begin
        e_mon = exp_q.pop_front();
        chk("wb_reg", 32'(dut.wb_rd), 32'(e_mon.r));
        chk("wb_val", dut.wb_d, e_mon.v);
      end
    end
    if (cnt_on) begin
      n_stall += int'(stall_o);
      if (flush_pend) pc_after_flush = pc_o;
      flush_pend = flush_o;
      n_flush += int'(flush_o);
    end
  end
  task automatic load(input int len);
    rst_i = 1'b1;
    start_i = 1'b0;
    tick();
    for (int i = 0; i < 256; i++) dut.imem[i] = i < len ? prog[i] : 32'd0;
    for (int i = 0; i < 32; i++) begin
      dut.rf[i] = 32'd0;
      dut.dmem[i] = mem0[i];
    end
    tick();
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_flush", 32'(flush_o), 32'd0);
  endtask
  task automatic run_prog(input int len, input int cycles);
    exp_q.delete();
    load(len);
    model(len);
    sb_on = 1;
    n_stall = 0;
    n_flush = 0;
    flush_pend = 0;
    pc_after_flush = '1;
    cnt_on = 1;
    rst_i = 1'b0;
    start_i = 1'b1;
    repeat (cycles) tick();
    start_i = 1'b0;
    repeat (8) tick();
    cnt_on = 0;
    sb_on = 0;
    chk("wb_pending", 32'(exp_q.size()), 32'd0);
    for (int r = 1; r < 16; r++) chk($sformatf("rf%0d", r), dut.rf[r], m_rf[r]);
    for (int b = 0; b < 32; b++) chk($sformatf("dmem%0d", b), 32'(dut.dmem[b]), 32'(m_mem[b]));
  endtask
  function automatic int gen();
    logic [5:0] fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h18};
    int bops [4] = '{0, 10, 11, 12};
    int len;
    len = 30;
    prog[0] = i_op(6'h08, 10, 0, 16'($urandom_range(0, 1)));
    prog[1] = i_op(6'h08, 11, 0, 16'($urandom_range(0, 1)));
    prog[2] = i_op(6'h08, 12, 0, 16'd0);
    prog[3] = 32'd0;
    prog[4] = 32'd0;
    for (int i = 5; i < len; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 9: prog[i] = r_op(fns[$urandom_range(0, 4)], $urandom_range(1, 7), $urandom_range(0, 7), $urandom_range(0, 7));
        4: prog[i] = i_op(6'h08, $urandom_range(1, 7), $urandom_range(0, 7), 16'($urandom));
        5: prog[i] = i_op(6'h23, $urandom_range(1, 7), 0, 16'(4 * $urandom_range(0, 7)));
        6: prog[i] = i_op(6'h2B, $urandom_range(0, 7), 0, 16'(4 * $urandom_range(0, 7)));
        7: prog[i] = i_op(6'h04, bops[$urandom_range(0, 3)], bops[$urandom_range(0, 3)], 16'($urandom_range(0, 3)));
        default: prog[i] = $urandom_range(0, 1) ? {6'h3F, 26'($urandom)} : {6'd0, 20'($urandom), 6'h21};
      endcase
    end
    return len;
  endfunction
  task automatic clr();
    for (int i = 0; i < 32; i++) mem0[i] = 8'd0;
    for (int i = 0; i < 256; i++) prog[i] = 32'd0;
  endtask
  initial begin
    logic [31:0] v;
    int len;
    clr();
    mem0[0] = 8'd5;
    prog[0] = i_op(6'h23, 8, 0, 16'd0);
    run_prog(1, 20);
    chk("lw_r8", dut.rf[8], 32'd5);
    chk("lw_dmem0", 32'(dut.dmem[0]), 32'd5);
    clr();
    prog[0] = i_op(6'h08, 1, 0, 16'd3);
    prog[1] = r_op(6'h20, 2, 1, 1);
    prog[2] = r_op(6'h22, 3, 2, 1);
    run_prog(3, 20);
    chk("fwd_r2", dut.rf[2], 32'd6);
    chk("fwd_r3", dut.rf[3], 32'd3);
    chk("fwd_stalls", 32'(n_stall), 32'd0);
    clr();
    mem0[0] = 8'd5;
    prog[0] = i_op(6'h23, 8, 0, 16'd0);
    prog[1] = r_op(6'h20, 9, 8, 8);
    run_prog(2, 20);
    chk("lu_stalls", 32'(n_stall), 32'd1);
    chk("lu_r9", dut.rf[9], 32'd10);
    clr();
    prog[0] = i_op(6'h08, 1, 0, 16'd1);
    prog[3] = i_op(6'h04, 1, 1, 16'd2);
    prog[4] = i_op(6'h08, 5, 0, 16'd7);
    prog[5] = i_op(6'h08, 6, 0, 16'd7);
    prog[6] = i_op(6'h08, 7, 0, 16'd9);
    run_prog(7, 25);
    chk("beq_flushes", 32'(n_flush), 32'd1);
    chk("beq_target", pc_after_flush, 32'h18);
    chk("beq_skip_r5", dut.rf[5], 32'd0);
    chk("beq_skip_r6", dut.rf[6], 32'd0);
    chk("beq_land_r7", dut.rf[7], 32'd9);
    clr();
    prog[0] = {6'h02, 26'd8};
    for (int i = 1; i < 8; i++) prog[i] = i_op(6'h08, 5, 0, 16'd1);
    prog[8] = i_op(6'h08, 4, 0, 16'd4);
    run_prog(9, 25);
    chk("j_flushes", 32'(n_flush), 32'd1);
    chk("j_target", pc_after_flush, 32'h20);
    chk("j_r4", dut.rf[4], 32'd4);
    chk("j_skip_r5", dut.rf[5], 32'd0);
    clr();
    prog[0] = i_op(6'h08, 2, 0, 16'd6);
    prog[1] = i_op(6'h2B, 2, 0, 16'd4);
    run_prog(2, 20);
    chk("sw_word4", {dut.dmem[7], dut.dmem[6], dut.dmem[5], dut.dmem[4]}, 32'd6);
    for (int k = 0; k < 3; k++) begin
      clr();
      for (int i = 0; i < 12; i++) prog[i] = i_op(6'h08, 1, 1, 16'd1);
      prog[12] = {6'h02, 26'd0};
      exp_q.delete();
      load(13);
      rst_i = 1'b0;
      start_i = 1'b1;
      repeat (20 + k) tick();
      v = dut.rf[1];
      rst_i = 1'b1;
      start_i = 1'b0;
      tick();
      chk("mid_rst_pc", pc_o, 32'd0);
      chk("mid_rst_stall", 32'(stall_o), 32'd0);
      chk("mid_rst_flush", 32'(flush_o), 32'd0);
      rst_i = 1'b0;
      repeat (6) tick();
      chk("mid_rst_progress", 32'(v > 0), 32'd1);
      chk("mid_rst_no_stale", dut.rf[1], v);
      chk("mid_rst_pc_hold", pc_o, 32'd0);
    end
    for (int t = 0; t < 15; t++) begin
      clr();
      for (int i = 0; i < 32; i++) mem0[i] = 8'($urandom);
      len = gen();
      run_prog(len, 2 * len + 20);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
